// File: rtl/bit_packer.sv
// bit_packer: packs 1..15-bit fields MSB-first into 32-bit words behind a ready/valid FIFO.
// Optional scan chain through cnt/acc enabled by defining BIT_PACKER_SCAN_EN.
module bit_packer #(
    parameter int WORD_W  = 32,
    parameter int FIELD_W = 15,
    parameter int LEN_W   = 4,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pushin,
    input  logic [LEN_W-1:0]   lenin,
    input  logic [FIELD_W-1:0] datain,
    input  logic               flushin,
    output logic               stallout,
    output logic               pushout,
    input  logic               readyin,
    output logic [WORD_W-1:0]  dataout,
    output logic [5:0]         lenout,
    input  logic               scanIn,
    input  logic               scanEnable,
    output logic               scanOut
);
    localparam int ACC_W = WORD_W + FIELD_W - 1;
    localparam int PW    = $clog2(DEPTH);

    logic [ACC_W-1:0]  acc, field, merged;
    logic [5:0]        cnt;
    logic [6:0]        total;
    logic              flush_pend, scan_en, scan_di;
    logic              push_ok, flush_req, flush_go, full_word, wr, rd;
    logic [WORD_W-1:0] wr_d;
    logic [5:0]        wr_l;
    logic [PW-1:0]     wptr, rptr;
    logic [PW:0]       occ;
    logic [WORD_W-1:0] mem_d [DEPTH];
    logic [5:0]        mem_l [DEPTH];

`ifdef BIT_PACKER_SCAN_EN
    assign scan_en = scanEnable;
    assign scan_di = scanIn;
    assign scanOut = acc[0];
`else
    logic unused_scan;
    assign unused_scan = scanIn ^ scanEnable;
    assign scan_en = 1'b0;
    assign scan_di = 1'b0;
    assign scanOut = 1'b0;
`endif

    // New field lands directly below the cnt residual bits, so acc stays zero below the valid bits
    assign field  = ACC_W'(datain & FIELD_W'((1 << lenin) - 1));
    assign merged = acc | (field << (ACC_W - int'(cnt) - int'(lenin)));
    assign total  = 7'(cnt) + 7'(lenin);

    assign stallout  = occ >= (PW+1)'(DEPTH - 1);
    assign pushout   = occ != '0;
    assign dataout   = mem_d[rptr];
    assign lenout    = mem_l[rptr];
    assign push_ok   = pushin & ~stallout & ~scan_en & (lenin != '0);
    assign flush_req = (flushin | flush_pend) & ~pushin & ~stallout & ~scan_en;
    assign flush_go  = flush_req & (cnt != '0);
    assign full_word = push_ok & (total >= 7'd32);
    assign wr        = full_word | flush_go;
    assign rd        = pushout & readyin;
    assign wr_d      = flush_go ? acc[ACC_W-1 -: WORD_W] : merged[ACC_W-1 -: WORD_W];
    assign wr_l      = flush_go ? cnt : 6'd32;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
            wptr       <= '0;
            rptr       <= '0;
            occ        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] <= '0;
                mem_l[i] <= '0;
            end
        end else begin
            if (scan_en)
                {cnt, acc} <= {scan_di, cnt, acc[ACC_W-1:1]};
            else if (flush_go) begin
                acc <= '0;
                cnt <= '0;
            end else if (push_ok) begin
                acc <= full_word ? merged << WORD_W : merged;
                cnt <= full_word ? 6'(total - 7'd32) : total[5:0];
            end
            flush_pend <= (pushin & flushin & ~stallout & ~scan_en) ? 1'b1 : (flush_req ? 1'b0 : flush_pend);
            if (wr) begin
                mem_d[wptr] <= wr_d;
                mem_l[wptr] <= wr_l;
                wptr        <= wptr + 1'b1;
            end
            if (rd)
                rptr <= rptr + 1'b1;
            occ <= occ + (PW+1)'(wr) - (PW+1)'(rd);
        end
    end
endmodule

// File: tb/tb_bit_packer.sv
// tb_bit_packer: table-driven directed vectors plus hand-written FIFO-fill, mid-reset and scan sequences.
module tb_bit_packer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        pushin = 1'b0, flushin = 1'b0, readyin = 1'b0;
    logic [3:0]  lenin = '0;
    logic [14:0] datain = '0;
    logic        stallout, pushout, scanIn = 1'b0, scanEnable = 1'b0, scanOut;
    logic [31:0] dataout;
    logic [5:0]  lenout;
    int          checks = 0, errors = 0;

    typedef struct {
        string       name;
        logic        push, flush, ready;
        logic [3:0]  len;
        logic [14:0] data;
        logic        po, st;
        logic [31:0] d;
        logic [5:0]  l;
    } vec_t;
    vec_t vecs[$];

    bit_packer dut (
        .clk(clk), .rst(rst), .pushin(pushin), .lenin(lenin), .datain(datain),
        .flushin(flushin), .stallout(stallout), .pushout(pushout), .readyin(readyin),
        .dataout(dataout), .lenout(lenout), .scanIn(scanIn), .scanEnable(scanEnable),
        .scanOut(scanOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic push, input logic flush, input logic ready,
                       input logic [3:0] len, input logic [14:0] data, input logic po,
                       input logic st, input logic [31:0] d, input logic [5:0] l);
        vec_t v;
        v.name = name; v.push = push; v.flush = flush; v.ready = ready; v.len = len;
        v.data = data; v.po = po; v.st = st; v.d = d; v.l = l;
        vecs.push_back(v);
    endtask

    task automatic cyc(input logic push, input logic flush, input logic ready,
                       input logic [3:0] len, input logic [14:0] data);
        pushin = push; flushin = flush; readyin = ready; lenin = len; datain = data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        pushin = 0; flushin = 0; readyin = 0; scanEnable = 0; scanIn = 0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [51:0] cap;
        // Expected word 0xFFFE0003 from 15 ones, 15 zeros, then 2'b11
        add("t2_p1", 1, 0, 1, 15, 15'h7FFF, 0, 0, 0, 0);
        add("t2_p2", 1, 0, 1, 15, 15'h0000, 0, 0, 0, 0);
        add("t2_p3", 1, 0, 1, 2,  15'h0003, 1, 0, 32'hFFFE0003, 32);
        add("t2_pop", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add("t3_fill", 1, 0, 1, 3, 15'h7FF5, 0, 0, 0, 0);
        add("t3_word", 1, 0, 1, 3, 15'h0005, 1, 0, 32'hB6DB6DB6, 32);
        add("t3_flush", 0, 1, 1, 0, 0, 1, 0, 32'h80000000, 1);
        add("t3_pop", 0, 0, 1, 0, 0, 0, 0, 0, 0);
        add("t5_len0", 1, 0, 1, 0, 15'h7FFF, 0, 0, 0, 0);
        add("t5_flush0", 0, 1, 1, 0, 0, 0, 0, 0, 0);
        add("t5_pf", 1, 1, 1, 1, 15'h0001, 0, 0, 0, 0);
        add("t5_pend", 0, 0, 1, 0, 0, 1, 0, 32'h80000000, 1);
        add("t5_pop", 0, 0, 1, 0, 0, 0, 0, 0, 0);

        do_reset();
        check("rst_pushout", pushout, 0);
        check("rst_stallout", stallout, 0);
        check("rst_lenout", lenout, 0);
        check("rst_dataout", dataout, 0);
        check("rst_scanout", scanOut, 0);

        foreach (vecs[k]) begin
            cyc(vecs[k].push, vecs[k].flush, vecs[k].ready, vecs[k].len, vecs[k].data);
            check({vecs[k].name, "_pushout"}, pushout, vecs[k].po);
            check({vecs[k].name, "_stallout"}, stallout, vecs[k].st);
            if (vecs[k].po) begin
                check({vecs[k].name, "_dataout"}, dataout, vecs[k].d);
                check({vecs[k].name, "_lenout"}, lenout, vecs[k].l);
            end
        end

        // Fill FIFO with readyin=0 using byte fields (upper garbage bits must be masked)
        for (int i = 0; i < 12; i++) begin
            cyc(1, 0, 0, 8, 15'h7F00 | 15'((i + 1) * 'h11));
            if (i == 3) begin
                check("t4_first_valid", pushout, 1);
                check("t4_first_data", dataout, 32'h11223344);
            end
            if (i == 7) check("t4_stall_at2", stallout, 0);
        end
        check("t4_stall_at3", stallout, 1);
        check("t4_hold_data", dataout, 32'h11223344);
        check("t4_hold_len", lenout, 32);
        cyc(0, 0, 1, 0, 0);
        check("t4_stall_drop", stallout, 0);
        check("t4_word2", dataout, 32'h55667788);
        cyc(0, 0, 1, 0, 0);
        check("t4_word3", dataout, 32'h99AABBCC);
        check("t4_valid3", pushout, 1);
        cyc(0, 0, 1, 0, 0);
        check("t4_empty", pushout, 0);

        // Reset in the middle of a partial word must discard the residual bits
        cyc(1, 0, 1, 15, 15'h7FFF);
        do_reset();
        check("mid_rst_pushout", pushout, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("mid_rst_flush", pushout, 0);

`ifdef BIT_PACKER_SCAN_EN
        do_reset();
        cyc(1, 0, 1, 3, 15'h0005);
        cyc(1, 0, 1, 2, 15'h0002);
        pushin = 0;
        scanEnable = 1;
        scanIn = 0;
        for (int i = 0; i < 52; i++) begin
            cap[i] = scanOut;
            @(posedge clk);
            #1;
        end
        scanEnable = 0;
        check("scan_stream", cap, {6'd5, 5'b10110, 41'b0});
        check("scan_after", scanOut, 0);
        cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("scan_cleared", pushout, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
